// File: rtl/accumulator_operand_pool.sv
// Memory-side responder on the accumulator op/ack bus: preloaded operand FIFO serving
// FETCH/STORE requests, declaring the final sum once a single operand is left.
module accumulator_operand_pool #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] write_data,
  output logic              ack,
  output logic              hit,
  output logic [DATA_W-1:0] read_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {ST_LOAD, ST_SERVE, ST_DONE} state_e;

  localparam logic [1:0]        OP_FETCH = 2'b01;
  localparam logic [1:0]        OP_STORE = 2'b10;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_C    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   TWO_C    = (ADDR_W + 1)'(2);
  localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     count_q, count_d, outst_q, outst_d;
  logic                ack_q, ack_d, hit_q, hit_d;
  logic                overflow_q, overflow_d, done_q, done_d;
  logic [DATA_W-1:0]   read_data_q, read_data_d, result_q, result_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rd_word;
  logic                is_full;
  logic                accept;

  assign rd_word = mem_q[rd_ptr_q];
  assign is_full = (count_q == DEPTH_C);
  // A request is taken only while no ack is on the bus, so a held op cannot be accepted twice.
  assign accept  = (state_q == ST_SERVE) && !ack_q && ((op == OP_FETCH) || (op == OP_STORE));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    outst_d     = outst_q;
    ack_d       = 1'b0;
    hit_d       = 1'b0;
    overflow_d  = overflow_q;
    done_d      = done_q;
    read_data_d = read_data_q;
    result_d    = result_q;
    mem_we      = 1'b0;
    mem_wdata   = load_data;

    unique case (state_q)
      ST_LOAD: begin
        if (load_valid) begin
          if (is_full) begin
            overflow_d = 1'b1;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            count_d  = count_q + ONE_C;
          end
        end else if (count_q != '0) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (accept) begin
          ack_d = 1'b1;
          if (op == OP_FETCH) begin
            if (count_q != '0) begin
              hit_d       = 1'b1;
              read_data_d = rd_word;
              rd_ptr_d    = rd_ptr_q + PTR_ONE;
              count_d     = count_q - ONE_C;
              outst_d     = outst_q + ONE_C;
            end
          end else begin
            mem_wdata = write_data;
            if (is_full) begin
              overflow_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_ONE;
              count_d  = count_q + ONE_C;
            end
            outst_d = (outst_q >= TWO_C) ? outst_q - TWO_C : '0;
          end
        end else if (!ack_q && (count_q == ONE_C) && (outst_q == '0)) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = rd_word;
        end
      end
      ST_DONE: ;
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: the operand storage carries no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_LOAD;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      ack_q       <= 1'b0;
      hit_q       <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      read_data_q <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      ack_q       <= ack_d;
      hit_q       <= hit_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      read_data_q <= read_data_d;
      result_q    <= result_d;
    end
  end

  assign ack       = ack_q;
  assign hit       = hit_q;
  assign read_data = read_data_q;
  assign full      = is_full;
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_accumulator_operand_pool.sv
// Bench for accumulator_operand_pool (DEPTH=4): directed scenarios plus randomized traffic
// compared against a queue-based model of the pool.
module tb_accumulator_operand_pool;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int SW    = 2 + DW + (AW + 1) + 4 + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic [1:0]    op = 2'b00;
  logic [DW-1:0] write_data = '0;
  logic          ack, hit, full, empty, overflow, done;
  logic [DW-1:0] read_data, result;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  accumulator_operand_pool #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .op(op), .write_data(write_data), .ack(ack), .hit(hit), .read_data(read_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow), .done(done),
    .result(result)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: operand pool as a queue, plus bus/result bookkeeping.
  logic [DW-1:0] mq[$];
  int            m_out;
  bit            m_ovf, m_ack_pend;
  logic [DW-1:0] m_rd, m_res;
  int            m_state;  // 0 load, 1 serve, 2 done

  wire [SW-1:0] dut_st = {ack, ack & hit, read_data, count, full, empty, overflow, done, result};

  function automatic logic [SW-1:0] exp_st(bit e_ack, bit e_hit);
    logic [AW:0] c;
    c = (AW + 1)'(mq.size());
    return {e_ack, e_ack & e_hit, m_rd, c, mq.size() == DEPTH, mq.size() == 0,
            m_ovf, m_state == 2, m_res};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic m_clear();
    mq.delete();
    m_out = 0; m_ovf = 0; m_ack_pend = 0; m_rd = '0; m_res = '0; m_state = 0;
  endtask

  task automatic drv_reset();
    reset = 1'b1; op = 2'b00; load_valid = 1'b0;
    step();
    reset = 1'b0;
    m_clear();
  endtask

  task automatic drv_load(input logic [DW-1:0] d);
    load_valid = 1'b1; load_data = d;
    step();
    load_valid = 1'b0;
    if (m_state == 0) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1;
    end
  endtask

  task automatic drv_load_end();
    load_valid = 1'b0;
    step();
    if (m_state == 0 && mq.size() > 0) m_state = 1;
  endtask

  // Model of one clock edge seen with op=o on the bus.
  task automatic m_edge(input logic [1:0] o, input logic [DW-1:0] d,
                        output bit e_ack, output bit e_hit);
    e_ack = 0; e_hit = 0;
    if (m_state == 1 && !m_ack_pend && (o == 2'b01 || o == 2'b10)) begin
      e_ack = 1; m_ack_pend = 1;
      if (o == 2'b01) begin
        if (mq.size() > 0) begin
          e_hit = 1; m_rd = mq.pop_front(); m_out++;
        end
      end else begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovf = 1;
        m_out = (m_out >= 2) ? m_out - 2 : 0;
      end
    end else if (m_ack_pend) begin
      m_ack_pend = 0;
    end else if (m_state == 1 && mq.size() == 1 && m_out == 0) begin
      m_state = 2; m_res = mq[0];
    end
  endtask

  task automatic drv_op(input logic [1:0] o, input logic [DW-1:0] d,
                        output bit e_ack, output bit e_hit);
    op = o; write_data = d;
    step();
    op = 2'b00;
    m_edge(o, d, e_ack, e_hit);
  endtask

  task automatic test_reset();
    drv_reset();
    if (dut_st !== exp_st(0, 0)) $display("FAIL reset_state: dut=%h exp=%h", dut_st, exp_st(0, 0));
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_pairwise();
    bit ea, eh;
    logic [DW-1:0] v0, v1;
    drv_reset();
    for (int i = 1; i <= 4; i++) drv_load(DW'(i));
    drv_load_end();
    if (dut_st !== exp_st(0, 0)) $display("FAIL pair_loaded: dut=%h exp=%h", dut_st, exp_st(0, 0));
    else n_pass++;
    n_checks++;
    for (int r = 0; r < 3; r++) begin
      drv_op(2'b01, '0, ea, eh); v0 = m_rd;
      if (dut_st !== exp_st(ea, eh)) $display("FAIL pair_fetch0 r%0d: dut=%h exp=%h", r, dut_st, exp_st(ea, eh));
      else n_pass++;
      n_checks++;
      drv_op(2'b00, '0, ea, eh);
      if (dut_st !== exp_st(ea, eh)) $display("FAIL pair_ackdrop r%0d: dut=%h exp=%h", r, dut_st, exp_st(ea, eh));
      else n_pass++;
      n_checks++;
      drv_op(2'b01, '0, ea, eh); v1 = m_rd;
      drv_op(2'b00, '0, ea, eh);
      drv_op(2'b10, v0 + v1, ea, eh);
      if (dut_st !== exp_st(ea, eh)) $display("FAIL pair_store r%0d: dut=%h exp=%h", r, dut_st, exp_st(ea, eh));
      else n_pass++;
      n_checks++;
      drv_op(2'b00, '0, ea, eh);
    end
    drv_op(2'b00, '0, ea, eh);
    if (dut_st !== exp_st(ea, eh)) $display("FAIL pair_done: dut=%h exp=%h", dut_st, exp_st(ea, eh));
    else n_pass++;
    n_checks++;
    if (result !== 32'd10 || done !== 1'b1 || count !== 3'd1)
      $display("FAIL pair_result: result=%0d done=%b count=%0d want 10 1 1", result, done, count);
    else n_pass++;
    n_checks++;
    drv_op(2'b01, '0, ea, eh);
    if (dut_st !== exp_st(ea, eh)) $display("FAIL done_ignores_req: dut=%h exp=%h", dut_st, exp_st(ea, eh));
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_single_word();
    bit ea, eh;
    drv_reset();
    drv_load(32'h55);
    drv_load_end();
    drv_op(2'b00, '0, ea, eh);
    if (dut_st !== exp_st(ea, eh) || result !== 32'h55 || done !== 1'b1)
      $display("FAIL single_word: dut=%h exp=%h", dut_st, exp_st(ea, eh));
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_fetch_empty();
    bit ea, eh;
    logic [DW-1:0] a, b;
    drv_reset();
    a = $urandom(); b = $urandom();
    drv_load(a); drv_load(b); drv_load_end();
    repeat (2) begin
      drv_op(2'b01, '0, ea, eh);
      drv_op(2'b00, '0, ea, eh);
    end
    drv_op(2'b01, '0, ea, eh);
    if (dut_st !== exp_st(ea, eh) || ack !== 1'b1 || hit !== 1'b0 || read_data !== b)
      $display("FAIL fetch_empty_miss: dut=%h exp=%h", dut_st, exp_st(ea, eh));
    else n_pass++;
    n_checks++;
    drv_op(2'b00, '0, ea, eh);
    drv_op(2'b10, a + b, ea, eh);
    drv_op(2'b00, '0, ea, eh);
    drv_op(2'b00, '0, ea, eh);
    if (dut_st !== exp_st(ea, eh) || result !== a + b)
      $display("FAIL fetch_empty_done: dut=%h exp=%h", dut_st, exp_st(ea, eh));
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_overflow_wrap();
    bit ea, eh;
    drv_reset();
    for (int i = 0; i < 5; i++) begin
      drv_load($urandom());
      if (i >= 3) begin
        if (dut_st !== exp_st(0, 0)) $display("FAIL ovf_load%0d: dut=%h exp=%h", i, dut_st, exp_st(0, 0));
        else n_pass++;
        n_checks++;
      end
    end
    drv_load_end();
    drv_op(2'b10, 32'hdead_beef, ea, eh);
    if (dut_st !== exp_st(ea, eh)) $display("FAIL ovf_store_full: dut=%h exp=%h", dut_st, exp_st(ea, eh));
    else n_pass++;
    n_checks++;
    drv_op(2'b00, '0, ea, eh);
    for (int k = 0; k < 10; k++) begin
      drv_op(2'b01, '0, ea, eh);
      if (dut_st !== exp_st(ea, eh)) $display("FAIL wrap_fetch%0d: dut=%h exp=%h", k, dut_st, exp_st(ea, eh));
      else n_pass++;
      n_checks++;
      drv_op(2'b00, '0, ea, eh);
      drv_op(2'b10, m_rd ^ DW'(k), ea, eh);
      drv_op(2'b00, '0, ea, eh);
    end
  endtask

  task automatic test_back_to_back();
    bit ea, eh;
    drv_reset();
    for (int i = 0; i < 3; i++) drv_load($urandom());
    drv_load_end();
    op = 2'b01;
    step();
    m_edge(2'b01, '0, ea, eh);
    if (dut_st !== exp_st(ea, eh)) $display("FAIL held_first: dut=%h exp=%h", dut_st, exp_st(ea, eh));
    else n_pass++;
    n_checks++;
    step();
    m_edge(2'b01, '0, ea, eh);
    op = 2'b00;
    if (dut_st !== exp_st(ea, eh) || ack !== 1'b0 || count !== 3'd2)
      $display("FAIL held_second: dut=%h exp=%h", dut_st, exp_st(ea, eh));
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_reset_mid();
    bit ea, eh;
    drv_reset();
    drv_load($urandom()); drv_load($urandom()); drv_load_end();
    op = 2'b01; reset = 1'b1;
    step();
    reset = 1'b0; op = 2'b00;
    m_clear();
    drv_op(2'b00, '0, ea, eh);
    if (dut_st !== exp_st(0, 0) || ack !== 1'b0 || empty !== 1'b1)
      $display("FAIL reset_mid_noack: dut=%h exp=%h", dut_st, exp_st(0, 0));
    else n_pass++;
    n_checks++;
    drv_load(32'h7);
    if (dut_st !== exp_st(0, 0)) $display("FAIL reset_mid_load: dut=%h exp=%h", dut_st, exp_st(0, 0));
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_random();
    bit ea, eh;
    int r;
    logic [1:0] o;
    for (int it = 0; it < 6; it++) begin
      drv_reset();
      for (int i = 0; i < $urandom_range(1, 5); i++) drv_load($urandom());
      drv_load_end();
      for (int k = 0; k < 60 && m_state != 2; k++) begin
        r = $urandom_range(0, 9);
        o = (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : (r == 7) ? 2'b00 : 2'b11;
        drv_op(o, $urandom(), ea, eh);
        if (dut_st !== exp_st(ea, eh))
          $display("FAIL rand it%0d k%0d op%0d: dut=%h exp=%h", it, k, o, dut_st, exp_st(ea, eh));
        else n_pass++;
        n_checks++;
      end
    end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_pairwise();
    test_single_word();
    test_fetch_empty();
    test_overflow_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
